// File: rtl/timer_tick_ctrl_pkg.sv
// Shared definitions for the digit-countdown run controller: state encodings
// and the reconfig decode used by the output register.
package timer_tick_ctrl_pkg;

    localparam int TIMER_ST_W = 3;

    typedef enum logic [TIMER_ST_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_EXPIRED = 3'd4
    } timer_st_e;

    // Digits follow the scaling input only while idle or reloading.
    function automatic logic st_drives_reconfig(input timer_st_e st);
        logic res;
        case (st)
            ST_IDLE, ST_LOAD: res = 1'b1;
            default:          res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider producing a registered one-cycle tick the cycle after the
// counter reaches DIV-1; clr has priority over en and kills a pending tick.
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST_C = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;
    logic          wrap_s;

    // Terminal count detect at full counter width.
    always_comb begin
        wrap_s = (cnt_r == LAST_C);
    end

    // Counter and tick register; a disabled counter simply holds its value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else if (clr) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else if (en) begin
            if (wrap_s) begin
                cnt_r  <= {CW{1'b0}};
                tick_r <= 1'b1;
            end else begin
                cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                tick_r <= 1'b0;
            end
        end else begin
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/timer_tick_ctrl.sv
// Run controller for the cascaded digit countdown: sequences load/run/pause/
// expire, drives digit reconfig and the 1 s borrow tick, and flags timeout.
module timer_tick_ctrl #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 1,
    parameter int LOAD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    input  logic       expired_in,
    output logic       reconfig,
    output logic       tick,
    output logic       running,
    output logic       timeout,
    output logic [2:0] state_dbg
);

    import timer_tick_ctrl_pkg::*;

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int LW  = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYCLES - 1);

    timer_st_e         state_r;
    timer_st_e         next_state_s;
    logic [LW-1:0]     load_cnt_r;
    logic              load_done_s;
    logic              presc_en_s;
    logic              presc_clr_s;
    logic              presc_tick_s;
    logic              reconfig_r;
    logic              running_r;
    logic              timeout_r;

    // Next-state decode; abort overrides everything, expired_in is ignored in LOAD.
    always_comb begin
        next_state_s = state_r;
        load_done_s  = (load_cnt_r == LOAD_LAST);
        if (abort) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) next_state_s = ST_LOAD;
                    else       next_state_s = ST_IDLE;
                end
                ST_LOAD: begin
                    if (!load_done_s) next_state_s = ST_LOAD;
                    else if (pause)   next_state_s = ST_PAUSE;
                    else              next_state_s = ST_RUN;
                end
                ST_RUN, ST_PAUSE: begin
                    if (expired_in) next_state_s = ST_EXPIRED;
                    else if (pause) next_state_s = ST_PAUSE;
                    else            next_state_s = ST_RUN;
                end
                ST_EXPIRED: begin
                    if (start) next_state_s = ST_LOAD;
                    else       next_state_s = ST_EXPIRED;
                end
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // Prescaler only advances on cycles that stay in RUN, so pause/expire/abort
    // on the wrap cycle suppress the tick and a pause freezes the partial second.
    always_comb begin
        presc_en_s  = (state_r == ST_RUN) && (next_state_s == ST_RUN);
        presc_clr_s = abort || (state_r == ST_IDLE) || (state_r == ST_LOAD);
    end

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en_s),
        .clr  (presc_clr_s),
        .tick (presc_tick_s)
    );

    // LOAD dwell counter, zero whenever the next cycle is not a continued LOAD.
    always_ff @(posedge clk) begin
        if (!rst) begin
            load_cnt_r <= {LW{1'b0}};
        end else if ((state_r == ST_LOAD) && (next_state_s == ST_LOAD)) begin
            load_cnt_r <= load_cnt_r + {{(LW-1){1'b0}}, 1'b1};
        end else begin
            load_cnt_r <= {LW{1'b0}};
        end
    end

    // State register and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            reconfig_r <= 1'b1;
            running_r  <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            reconfig_r <= st_drives_reconfig(next_state_s);
            running_r  <= (next_state_s == ST_RUN);
            timeout_r  <= (next_state_s == ST_EXPIRED) && (state_r != ST_EXPIRED);
        end
    end

    assign reconfig  = reconfig_r;
    assign tick      = presc_tick_s;
    assign running   = running_r;
    assign timeout   = timeout_r;
    assign state_dbg = state_r;

endmodule

// File: tb/tb_timer_tick_ctrl.sv
// Scoreboard bench for timer_tick_ctrl: a cycle model and directed tick
// timestamps both queue expectations that are popped as the DUT responds.
module tb_timer_tick_ctrl;

    localparam int CLK_HZ      = 10;
    localparam int TICK_HZ     = 1;
    localparam int LOAD_CYCLES = 2;
    localparam int DIV         = CLK_HZ / TICK_HZ;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       start      = 1'b0;
    logic       pause      = 1'b0;
    logic       abort      = 1'b0;
    logic       expired_in = 1'b0;
    logic       reconfig;
    logic       tick;
    logic       running;
    logic       timeout;
    logic [2:0] state_dbg;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    logic [6:0] exp_q[$];
    int         tick_q[$];

    int   m_st   = 0;
    int   m_rem  = DIV;
    int   m_ld   = 0;
    logic m_rcfg = 1'b1;
    logic m_tick = 1'b0;
    logic m_run  = 1'b0;
    logic m_to   = 1'b0;

    always #5 clk = ~clk;

    timer_tick_ctrl #(
        .CLK_HZ      (CLK_HZ),
        .TICK_HZ     (TICK_HZ),
        .LOAD_CYCLES (LOAD_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .abort      (abort),
        .expired_in (expired_in),
        .reconfig   (reconfig),
        .tick       (tick),
        .running    (running),
        .timeout    (timeout),
        .state_dbg  (state_dbg)
    );

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0h want %0h", tag, cyc_n, act, exp);
        end
    endtask

    // Behavioural model: remaining-cycles-to-tick accounting per RUN cycle.
    task automatic model_step();
        int nxt;
        if (!rst) begin
            m_st = 0; m_rem = DIV; m_ld = 0;
            m_rcfg = 1'b1; m_tick = 1'b0; m_run = 1'b0; m_to = 1'b0;
        end else begin
            if (abort) nxt = 0;
            else begin
                case (m_st)
                    0:       nxt = start ? 1 : 0;
                    1:       nxt = (m_ld >= LOAD_CYCLES - 1) ? (pause ? 3 : 2) : 1;
                    2, 3:    nxt = expired_in ? 4 : (pause ? 3 : 2);
                    4:       nxt = start ? 1 : 4;
                    default: nxt = 0;
                endcase
            end
            m_tick = 1'b0;
            if (m_st == 2 && nxt == 2) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_tick = 1'b1;
                    m_rem  = DIV;
                end
            end
            if (abort || (nxt == 1 && m_st != 1)) m_rem = DIV;
            m_ld   = (m_st == 1 && nxt == 1) ? m_ld + 1 : 0;
            m_to   = (nxt == 4 && m_st != 4);
            m_run  = (nxt == 2);
            m_rcfg = (nxt == 0 || nxt == 1);
            m_st   = nxt;
        end
    endtask

    task automatic cyc();
        logic [6:0] e;
        model_step();
        exp_q.push_back({m_rcfg, m_tick, m_run, m_to, 3'(m_st)});
        @(posedge clk);
        #1;
        cyc_n++;
        e = exp_q.pop_front();
        chk_eq("outputs", {25'd0, reconfig, tick, running, timeout, state_dbg}, {25'd0, e});
        if (tick_q.size() > 0 && tick_q[0] == cyc_n) begin
            chk_eq("tick_due", {31'd0, tick}, 32'd1);
            void'(tick_q.pop_front());
        end else if (tick) begin
            chk_eq("tick_extra", {31'd0, tick}, 32'd0);
        end
    endtask

    task automatic run_until(input int target);
        while (cyc_n < target) cyc();
    endtask

    initial begin
        int e0;
        int e2;
        int e3;

        // reset and idle
        rst = 1'b0;
        cyc(); cyc();
        chk_eq("rst_rcfg",  {31'd0, reconfig}, 32'd1);
        chk_eq("rst_tick",  {31'd0, tick},     32'd0);
        chk_eq("rst_state", {29'd0, state_dbg}, 32'd0);
        rst = 1'b1;
        repeat (3) cyc();
        chk_eq("idle_state", {29'd0, state_dbg}, 32'd0);
        chk_eq("idle_rcfg",  {31'd0, reconfig},  32'd1);

        // load then run, ticks every DIV cycles
        start = 1'b1; cyc(); start = 1'b0;
        chk_eq("load_state", {29'd0, state_dbg}, 32'd1);
        e0 = cyc_n + LOAD_CYCLES;
        tick_q.push_back(e0 + DIV);
        tick_q.push_back(e0 + 2 * DIV);
        cyc();
        chk_eq("load_rcfg", {31'd0, reconfig}, 32'd1);
        cyc();
        chk_eq("run_state", {29'd0, state_dbg}, 32'd2);
        chk_eq("run_rcfg",  {31'd0, reconfig},  32'd0);
        chk_eq("run_flag",  {31'd0, running},   32'd1);
        run_until(e0 + 2 * DIV + 4);

        // pause at count 4 for 25 cycles, resume 6 cycles short of a tick
        pause = 1'b1;
        repeat (25) cyc();
        chk_eq("pause_state", {29'd0, state_dbg}, 32'd3);
        chk_eq("pause_run",   {31'd0, running},   32'd0);
        pause = 1'b0;
        cyc();
        chk_eq("resume_state", {29'd0, state_dbg}, 32'd2);
        tick_q.push_back(cyc_n + (DIV - 4));
        tick_q.push_back(cyc_n + (DIV - 4) + DIV);
        run_until(cyc_n + (DIV - 4) + DIV + 4);

        // expiry in RUN
        expired_in = 1'b1; cyc(); expired_in = 1'b0;
        chk_eq("exp_state", {29'd0, state_dbg}, 32'd4);
        chk_eq("exp_to",    {31'd0, timeout},   32'd1);
        cyc();
        chk_eq("exp_to_once", {31'd0, timeout}, 32'd0);
        repeat (12) cyc();
        chk_eq("exp_rcfg", {31'd0, reconfig}, 32'd0);
        start = 1'b1; cyc(); start = 1'b0;
        chk_eq("reload_state", {29'd0, state_dbg}, 32'd1);
        chk_eq("reload_rcfg",  {31'd0, reconfig},  32'd1);
        cyc(); cyc();
        chk_eq("rerun_state", {29'd0, state_dbg}, 32'd2);

        // abort while paused
        repeat (3) cyc();
        pause = 1'b1;
        repeat (4) cyc();
        chk_eq("pause2_state", {29'd0, state_dbg}, 32'd3);
        abort = 1'b1; cyc(); abort = 1'b0; pause = 1'b0;
        chk_eq("abort_state", {29'd0, state_dbg}, 32'd0);
        chk_eq("abort_rcfg",  {31'd0, reconfig},  32'd1);

        // start+abort on the wrap cycle: IDLE and no tick
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        e2 = cyc_n;
        run_until(e2 + DIV - 1);
        start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
        chk_eq("sa_state", {29'd0, state_dbg}, 32'd0);
        chk_eq("sa_tick",  {31'd0, tick},      32'd0);
        chk_eq("sa_rcfg",  {31'd0, reconfig},  32'd1);
        cyc();
        chk_eq("sa_hold", {29'd0, state_dbg}, 32'd0);

        // expired_in on the wrap cycle
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        e3 = cyc_n;
        run_until(e3 + DIV - 1);
        expired_in = 1'b1; cyc(); expired_in = 1'b0;
        chk_eq("wrap_exp_tick",  {31'd0, tick},      32'd0);
        chk_eq("wrap_exp_to",    {31'd0, timeout},   32'd1);
        chk_eq("wrap_exp_state", {29'd0, state_dbg}, 32'd4);

        // reset mid-run, then a fresh run starts from a cleared prescaler
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        tick_q.push_back(cyc_n + DIV);
        run_until(cyc_n + DIV + 3);
        rst = 1'b0; cyc();
        chk_eq("mid_rst_rcfg",  {31'd0, reconfig},  32'd1);
        chk_eq("mid_rst_run",   {31'd0, running},   32'd0);
        chk_eq("mid_rst_to",    {31'd0, timeout},   32'd0);
        chk_eq("mid_rst_state", {29'd0, state_dbg}, 32'd0);
        cyc();
        rst = 1'b1;
        repeat (2) cyc();
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        tick_q.push_back(cyc_n + DIV);
        run_until(cyc_n + DIV + 2);

        chk_eq("tick_q_empty", tick_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
